entry_sequencer: RTL and testbench

Controller in front of the smart_room occupancy counter. It turns two raw doorway beam sensors into clean, single-cycle increment and decrement commands for the people counter. It also drives the door lock from the current count. Beam inputs are synchronised and debounced, then a direction-decoding FSM accepts only complete outer→inner (entry) or inner→outer (exit) sequences.

---
 rtl/smart_room_pkg.sv | 20 ++
 rtl/beam_debounce.sv | 39 +++
 rtl/entry_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_entry_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/smart_room_pkg.sv
// Shared types and default constants for the smart_room entry controller and counter.
package smart_room_pkg;

  localparam int unsigned DefDebounceCycles = 4;
  localparam int unsigned DefTimeoutCycles  = 64;
  localparam int unsigned DefMaxPeople      = 10;
  localparam int unsigned DefCntW           = 4;

  typedef enum logic [2:0] {
    StIdle,
    StEnt1,
    StEnt2,
    StEnt3,
    StExt1,
    StExt2,
    StExt3,
    StWaitClr
  } seq_state_t;

endpackage

// File: rtl/beam_debounce.sv
// Two-flop synchroniser plus stability counter for one raw doorway beam.
module beam_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            filt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      // Any return to the current filtered level restarts the stability count.
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/entry_sequencer.sv
// Doorway direction decoder: debounced beams -> single-cycle inc/dec commands and door lock.
// Optional sticky tailgate_alarm output when SMART_ROOM_TAILGATE_ALARM_EN is defined.
module entry_sequencer
  import smart_room_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned TIMEOUT_CYCLES  = DefTimeoutCycles,
  parameter int unsigned MAX_PEOPLE      = DefMaxPeople,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beam_outer,
  input  logic             beam_inner,
  input  logic [CNT_W-1:0] people_count,
  output logic             inc_pulse,
  output logic             dec_pulse,
  output logic             door_locked,
  output logic             seq_error,
  output logic             busy
`ifdef SMART_ROOM_TAILGATE_ALARM_EN
  ,
  output logic             tailgate_alarm
`endif
);

  localparam int unsigned TmrW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmrW-1:0]  TmrLast = TmrW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  logic filt_outer, filt_inner;

  beam_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_outer (
    .clk  (clk),
    .reset(reset),
    .raw  (beam_outer),
    .filt (filt_outer)
  );

  beam_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_inner (
    .clk  (clk),
    .reset(reset),
    .raw  (beam_inner),
    .filt (filt_inner)
  );

  seq_state_t      state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            inc_q, inc_d;
  logic            dec_q, dec_d;
  logic            err_q, err_d;
  logic            busy_q;
  logic            locked_q;
  logic            entry_done, exit_done;
  logic [1:0]      beams;

  assign beams = {filt_outer, filt_inner};

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    err_d      = 1'b0;
    entry_done = 1'b0;
    exit_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        case (beams)
          2'b10:   state_d = StEnt1;
          2'b01:   state_d = StExt1;
          2'b11: begin
            state_d = StWaitClr;
            err_d   = 1'b1;
          end
          default: state_d = StIdle;
        endcase
      end
      StEnt1: begin
        case (beams)
          2'b11:   state_d = StEnt2;
          2'b01:   state_d = StEnt3;
          2'b00:   state_d = StIdle;
          default: state_d = StEnt1;
        endcase
      end
      StEnt2: begin
        case (beams)
          2'b01:   state_d = StEnt3;
          2'b10:   state_d = StEnt1;
          2'b00: begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
          default: state_d = StEnt2;
        endcase
      end
      StEnt3: begin
        case (beams)
          2'b00: begin
            state_d    = StIdle;
            entry_done = 1'b1;
          end
          2'b11:   state_d = StEnt2;
          2'b10:   state_d = StEnt1;
          default: state_d = StEnt3;
        endcase
      end
      StExt1: begin
        case (beams)
          2'b11:   state_d = StExt2;
          2'b10:   state_d = StExt3;
          2'b00:   state_d = StIdle;
          default: state_d = StExt1;
        endcase
      end
      StExt2: begin
        case (beams)
          2'b10:   state_d = StExt3;
          2'b01:   state_d = StExt1;
          2'b00: begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
          default: state_d = StExt2;
        endcase
      end
      StExt3: begin
        case (beams)
          2'b00: begin
            state_d   = StIdle;
            exit_done = 1'b1;
          end
          2'b11:   state_d = StExt2;
          2'b01:   state_d = StExt1;
          default: state_d = StExt3;
        endcase
      end
      StWaitClr: begin
        if (beams == 2'b00) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Counter saturation turns a completed pass into an error instead of a command.
    if (entry_done) begin
      if (people_count == CntMax) begin
        err_d = 1'b1;
      end else begin
        inc_d = 1'b1;
      end
    end
    if (exit_done) begin
      if (people_count == '0) begin
        err_d = 1'b1;
      end else begin
        dec_d = 1'b1;
      end
    end

    if (state_d != state_q || state_q == StIdle || state_q == StWaitClr) begin
      tmr_d = '0;
    end else if (tmr_q == TmrLast) begin
      state_d = StWaitClr;
      err_d   = 1'b1;
      tmr_d   = '0;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      tmr_q    <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      err_q    <= err_d;
      busy_q   <= (state_d != StIdle);
      locked_q <= (32'(people_count) >= MAX_PEOPLE);
    end
  end

  assign inc_pulse   = inc_q;
  assign dec_pulse   = dec_q;
  assign seq_error   = err_q;
  assign busy        = busy_q;
  assign door_locked = locked_q;

`ifdef SMART_ROOM_TAILGATE_ALARM_EN
  logic tailgate_q;

  // Sticky: only reset clears it, so staff see every entry made against the lock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tailgate_q <= 1'b0;
    end else if (entry_done && locked_q) begin
      tailgate_q <= 1'b1;
    end
  end

  assign tailgate_alarm = tailgate_q;
`else
  // Default build carries no tailgate alarm state.
`endif

endmodule

// File: tb/tb_entry_sequencer.sv
// Scoreboard bench for entry_sequencer: stimulus queues expected pulses, a monitor pops them.
module tb_entry_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       beam_outer;
  logic       beam_inner;
  logic [3:0] people_count;
  logic       inc_pulse, dec_pulse, door_locked, seq_error, busy;
`ifdef SMART_ROOM_TAILGATE_ALARM_EN
  logic       tailgate_alarm;
`endif

  entry_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .beam_outer  (beam_outer),
    .beam_inner  (beam_inner),
    .people_count(people_count),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .door_locked (door_locked),
    .seq_error   (seq_error),
    .busy        (busy)
`ifdef SMART_ROOM_TAILGATE_ALARM_EN
    ,
    .tailgate_alarm(tailgate_alarm)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [2:0] EvInc = 3'b100;
  localparam logic [2:0] EvDec = 3'b010;
  localparam logic [2:0] EvErr = 3'b001;

  logic [2:0] exp_q[$];
  logic [2:0] ev_code;
  int         checks = 0;
  int         passes = 0;
  logic       busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Monitor: every pulse sample must match the next queued expectation.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_seen = 1'b1;
    if (inc_pulse === 1'b1 || dec_pulse === 1'b1 || seq_error === 1'b1) begin
      ev_code = {inc_pulse, dec_pulse, seq_error};
      if (exp_q.size() == 0) check("unexpected_pulse", 32'(ev_code), 32'(0));
      else check("pulse_event", 32'(ev_code), 32'(exp_q.pop_front()));
    end
  end

  task automatic hold(input logic o, input logic i, input int n);
    beam_outer = o;
    beam_inner = i;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    hold(1'b0, 1'b0, 15);
    check({name, "_pending"}, 32'(exp_q.size()), 32'(0));
    check({name, "_busy_idle"}, 32'(busy), 32'(0));
  endtask

  task automatic entry_walk();
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
  endtask

  task automatic exit_walk();
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
  endtask

  initial begin
    reset        = 1'b0;
    beam_outer   = 1'b0;
    beam_inner   = 1'b0;
    people_count = 4'd3;
    for (int k = 0; k < 3; k++) begin
      beam_outer = 1'($urandom_range(0, 1));
      beam_inner = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("rst_inc", 32'(inc_pulse), 32'(0));
    check("rst_dec", 32'(dec_pulse), 32'(0));
    check("rst_err", 32'(seq_error), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_locked", 32'(door_locked), 32'(0));
    reset = 1'b1;
    hold(1'b0, 1'b0, 20);
    check("post_rst_busy", 32'(busy), 32'(0));
    check("post_rst_pending", 32'(exp_q.size()), 32'(0));

    // Clean entry at count 3
    exp_q.push_back(EvInc);
    busy_seen = 1'b0;
    entry_walk();
    check("entry_busy_seen", 32'(busy_seen), 32'(1));
    drain("entry");

    // Mirrored exit at 3, then at 0 (suppressed -> error)
    exp_q.push_back(EvDec);
    exit_walk();
    drain("exit3");
    people_count = 4'd0;
    exp_q.push_back(EvErr);
    exit_walk();
    drain("exit0");
    people_count = 4'd3;

    // Short glitch never reaches the FSM
    busy_seen = 1'b0;
    hold(1'b1, 1'b0, 2);
    hold(1'b0, 1'b0, 15);
    check("glitch_busy_seen", 32'(busy_seen), 32'(0));

    // Back-out: busy but silent
    busy_seen = 1'b0;
    hold(1'b1, 1'b0, 10);
    check("backout_busy_seen", 32'(busy_seen), 32'(1));
    drain("backout");

    // Timeout in ENT1, then parked in WAIT_CLR until clear
    exp_q.push_back(EvErr);
    hold(1'b1, 1'b0, 100);
    check("timeout_waitclr_busy", 32'(busy), 32'(1));
    check("timeout_err_seen", 32'(exp_q.size()), 32'(0));
    drain("timeout");

    // Door lock latency and entry while locked
    people_count = 4'd10;
    #1;
    check("lock_before_edge", 32'(door_locked), 32'(0));
    @(negedge clk);
    check("lock_after_edge", 32'(door_locked), 32'(1));
    exp_q.push_back(EvInc);
    entry_walk();
    drain("locked_entry");
`ifdef SMART_ROOM_TAILGATE_ALARM_EN
    check("tailgate_set", 32'(tailgate_alarm), 32'(1));
`endif

    // Counter saturated: entry becomes an error
    people_count = 4'd15;
    exp_q.push_back(EvErr);
    entry_walk();
    drain("full_entry");
    check("full_locked", 32'(door_locked), 32'(1));

    // Both beams at once from IDLE
    people_count = 4'd3;
    exp_q.push_back(EvErr);
    hold(1'b1, 1'b1, 10);
    check("both_waitclr_busy", 32'(busy), 32'(1));
    drain("both");
    check("unlock", 32'(door_locked), 32'(0));
`ifdef SMART_ROOM_TAILGATE_ALARM_EN
    check("tailgate_sticky", 32'(tailgate_alarm), 32'(1));
`endif

    // Both clear together from ENT2
    exp_q.push_back(EvErr);
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    drain("ent2_abort");

    // Reset mid-sequence abandons it
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 5);
    reset      = 1'b0;
    beam_outer = 1'b0;
    beam_inner = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'(0));
`ifdef SMART_ROOM_TAILGATE_ALARM_EN
    check("tailgate_cleared", 32'(tailgate_alarm), 32'(0));
`endif
    reset = 1'b1;
    drain("midrst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
